pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, consecutive stalled cycles before the watchdog fires; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port stallreq_from_id  input  1  decode-stage hazard stall request.
REQ-005 SHALL have port stallreq_from_ex  input  1  execute-stage multi-cycle stall request.
REQ-006 SHALL have port stallreq_from_mem  input  1  memory-stage bus-wait stall request.
REQ-007 SHALL have port timeout_clr_i  input  1  clears the sticky timeout flag.
REQ-008 SHALL have port stall  output  6  per-stage hold vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = Stop.
REQ-009 SHALL have port stall_cause_o  output  2  registered cause of the previous cycle's stall: 0 none, 1 id, 2 ex, 3 mem.
REQ-010 SHALL have port state_o  output  2  FSM state: 0 RUN, 1 STALLED, 2 HUNG.
REQ-011 SHALL have port timeout_o  output  1  sticky watchdog flag.

Function
REQ-012 stall SHALL be combinational with zero latency, priority mem > ex > id: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, none -> 6'b000000.
REQ-013 stall SHALL depend only on the current requests in every FSM state, including HUNG; the watchdog never overrides a stall.
REQ-014 FSM RUN SHALL go to STALLED on any request, and otherwise remain in RUN.
REQ-015 FSM STALLED SHALL go to RUN when no request is active.
REQ-016 FSM STALLED SHALL go to HUNG on the edge where stall_cnt equals TIMEOUT_CYCLES-1 and a request is still active.
REQ-017 FSM HUNG SHALL go to RUN when no request is active, and otherwise remain in HUNG.
REQ-018 A 16-bit stall_cnt SHALL increment on each edge where any request is active, clear to 0 on each edge with no request, and saturate at 16'hFFFF.
REQ-019 stall_cause_o SHALL register the priority-encoded cause every cycle; a cause change mid-stall (e.g. ex→mem) SHALL NOT reset stall_cnt.
REQ-020 timeout_o SHALL be set on the STALLED→HUNG edge, hold until timeout_clr_i is sampled high, and set SHALL win over a simultaneous clear.
REQ-021 A single-cycle request SHALL produce exactly one cycle of nonzero stall and a STALLED→RUN round trip.

Reset
REQ-022 While rst=0, state SHALL be RUN, stall_cnt SHALL be 0, stall_cause_o SHALL be 0 and timeout_o SHALL be 0, asynchronously.
REQ-023 stall SHALL still follow the requests during reset, since it is combinational.
REQ-024 Reset asserted mid-stall SHALL discard the count, and the first active cycle after release SHALL be counted as stall cycle 1.

Configuration
REQ-025 With PIPE_CTRL_PERF_EN defined, the block SHALL add outputs perf_id_o, perf_ex_o and perf_mem_o (32 bits each).
REQ-026 Each perf counter SHALL increment on cycles whose combinational cause matches it, saturate at 32'hFFFFFFFF, reset to 0, and SHALL NOT be cleared by timeout_clr_i.
REQ-027 Without PIPE_CTRL_PERF_EN, the perf ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-028 The stall encodings, cause codes, FSM state codes and Stop/NoStop values SHALL live in the shared defines package alongside the existing pipeline constants.
REQ-029 The priority encode (requests → stall vector plus cause) SHALL be one combinational sub-module, stall_encode; the FSM, counters and flags SHALL stay in pipe_ctrl.

Verification
REQ-030 Reset scenario: hold rst=0 with all requests high → stall=6'b011111 and stall_cause_o=0, state_o=0, timeout_o=0.
REQ-031 Priority scenario: assert id+ex for 1 cycle → stall=6'b001111; on the next cycle stall_cause_o=2, state_o=1; then drop all requests → state_o=0 one edge later.
REQ-032 Watchdog scenario: TIMEOUT_CYCLES=4, hold ex for 6 cycles → state_o=2 and timeout_o=1 after the 4th edge; drop ex → state_o=0 and timeout_o stays 1.
REQ-033 Clear scenario: assert timeout_clr_i on the same edge as a new timeout → timeout_o=1; clear alone → timeout_o=0 next cycle.
REQ-034 Mid-stall reset scenario: hold mem for 3 cycles, pulse rst → stall_cnt=0 and state_o=0; keep mem high → timeout fires TIMEOUT_CYCLES edges after rst release.
REQ-035 Perf scenario (PIPE_CTRL_PERF_EN): 5 id cycles, 3 ex cycles and 2 idle cycles → perf_id_o=5, perf_ex_o=3, perf_mem_o=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline defines: widths, stall encodings, cause and FSM state codes.
package pipe_ctrl_pkg;

    // Existing pipeline constants
    localparam int unsigned InstAddrWidth = 32;
    localparam int unsigned InstDataWidth = 32;
    localparam int unsigned RegAddrWidth  = 5;
    localparam int unsigned RegDataWidth  = 32;

    // Per-stage hold values
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Stall vector layout: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
    localparam int unsigned StallWidth = 6;

    localparam logic [StallWidth-1:0] StallNone = {NoStop, NoStop, NoStop, NoStop, NoStop, NoStop};
    localparam logic [StallWidth-1:0] StallId   = {NoStop, NoStop, NoStop, Stop,   Stop,   Stop};
    localparam logic [StallWidth-1:0] StallEx   = {NoStop, NoStop, Stop,   Stop,   Stop,   Stop};
    localparam logic [StallWidth-1:0] StallMem  = {NoStop, Stop,   Stop,   Stop,   Stop,   Stop};

    // Stall cause codes
    typedef enum logic [1:0] {
        CauseNone = 2'd0,
        CauseId   = 2'd1,
        CauseEx   = 2'd2,
        CauseMem  = 2'd3
    } cause_e;

    // Controller FSM state codes
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StStalled = 2'd1,
        StHung    = 2'd2
    } state_e;

    localparam int unsigned CntWidth  = 16;
    localparam int unsigned PerfWidth = 32;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/stall bundle between the pipeline stages and pipe_ctrl.
// Perf counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                  stallreq_from_id;
    logic                  stallreq_from_ex;
    logic                  stallreq_from_mem;
    logic                  timeout_clr_i;
    logic [StallWidth-1:0] stall;
    logic [1:0]            stall_cause_o;
    logic [1:0]            state_o;
    logic                  timeout_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [PerfWidth-1:0]  perf_id_o;
    logic [PerfWidth-1:0]  perf_ex_o;
    logic [PerfWidth-1:0]  perf_mem_o;

    modport master (
        output stallreq_from_id, stallreq_from_ex, stallreq_from_mem, timeout_clr_i,
        input  stall, stall_cause_o, state_o, timeout_o, perf_id_o, perf_ex_o, perf_mem_o
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem, timeout_clr_i,
        output stall, stall_cause_o, state_o, timeout_o, perf_id_o, perf_ex_o, perf_mem_o
    );
`else
    modport master (
        output stallreq_from_id, stallreq_from_ex, stallreq_from_mem, timeout_clr_i,
        input  stall, stall_cause_o, state_o, timeout_o
    );

    modport slave (
        input  stallreq_from_id, stallreq_from_ex, stallreq_from_mem, timeout_clr_i,
        output stall, stall_cause_o, state_o, timeout_o
    );
`endif

endinterface

// File: rtl/pipe_ctrl_stall_encode.sv
// stall_encode: priority encode of stage stall requests (mem > ex > id)
// into the per-stage hold vector and the cause code. Purely combinational.
module stall_encode
    import pipe_ctrl_pkg::*;
(
    input  logic                  req_id_i,
    input  logic                  req_ex_i,
    input  logic                  req_mem_i,
    output logic [StallWidth-1:0] stall_o,
    output cause_e                cause_o
);

    // Later stages win: holding mem implies holding everything upstream.
    always_comb begin
        stall_o = StallNone;
        cause_o = CauseNone;
        if (req_mem_i) begin
            stall_o = StallMem;
            cause_o = CauseMem;
        end else if (req_ex_i) begin
            stall_o = StallEx;
            cause_o = CauseEx;
        end else if (req_id_i) begin
            stall_o = StallId;
            cause_o = CauseId;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall controller with stall watchdog.
// Stall vector is combinational from the requests; the FSM, stall counter,
// cause register and sticky timeout flag are registered.
// Optional: define PIPE_CTRL_PERF_EN to add per-cause perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave ctrl
);

    // Count value seen on the edge that trips the watchdog
    localparam logic [CntWidth-1:0] TimeoutLast = CntWidth'(TIMEOUT_CYCLES - 1);

    logic [StallWidth-1:0] stall_vec;
    cause_e                cause;
    logic                  any_req;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   stall_cnt_q, stall_cnt_d;
    cause_e                cause_q, cause_d;
    logic                  timeout_q, timeout_d;
    logic                  fire;

    stall_encode u_stall_encode (
        .req_id_i  (ctrl.stallreq_from_id),
        .req_ex_i  (ctrl.stallreq_from_ex),
        .req_mem_i (ctrl.stallreq_from_mem),
        .stall_o   (stall_vec),
        .cause_o   (cause)
    );

    assign any_req = ctrl.stallreq_from_id | ctrl.stallreq_from_ex | ctrl.stallreq_from_mem;

    // Next-state for FSM, saturating stall counter, cause and sticky timeout
    always_comb begin
        stall_cnt_d = '0;
        if (any_req) begin
            stall_cnt_d = (stall_cnt_q == {CntWidth{1'b1}}) ? stall_cnt_q : stall_cnt_q + 1'b1;
        end

        fire = (state_q == StStalled) && any_req && (stall_cnt_q == TimeoutLast);

        state_d = state_q;
        case (state_q)
            StRun:     state_d = any_req ? StStalled : StRun;
            StStalled: begin
                if (!any_req) begin
                    state_d = StRun;
                end else if (fire) begin
                    state_d = StHung;
                end
            end
            StHung:    state_d = any_req ? StHung : StRun;
            default:   state_d = StRun;
        endcase

        cause_d = cause;

        // A new timeout takes precedence over a simultaneous clear
        timeout_d = timeout_q;
        if (fire) begin
            timeout_d = 1'b1;
        end else if (ctrl.timeout_clr_i) begin
            timeout_d = 1'b0;
        end
    end

    // Controller state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            stall_cnt_q <= '0;
            cause_q     <= CauseNone;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            cause_q     <= cause_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ctrl.stall         = stall_vec;
    assign ctrl.stall_cause_o = cause_q;
    assign ctrl.state_o       = state_q;
    assign ctrl.timeout_o     = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [PerfWidth-1:0] perf_id_q, perf_id_d;
    logic [PerfWidth-1:0] perf_ex_q, perf_ex_d;
    logic [PerfWidth-1:0] perf_mem_q, perf_mem_d;

    // Saturating per-cause counters; only reset clears them
    always_comb begin
        perf_id_d  = perf_id_q;
        perf_ex_d  = perf_ex_q;
        perf_mem_d = perf_mem_q;
        case (cause)
            CauseId:  if (perf_id_q != {PerfWidth{1'b1}}) perf_id_d = perf_id_q + 1'b1;
            CauseEx:  if (perf_ex_q != {PerfWidth{1'b1}}) perf_ex_d = perf_ex_q + 1'b1;
            CauseMem: if (perf_mem_q != {PerfWidth{1'b1}}) perf_mem_d = perf_mem_q + 1'b1;
            default:  ;
        endcase
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_id_q  <= '0;
            perf_ex_q  <= '0;
            perf_mem_q <= '0;
        end else begin
            perf_id_q  <= perf_id_d;
            perf_ex_q  <= perf_ex_d;
            perf_mem_q <= perf_mem_d;
        end
    end

    assign ctrl.perf_id_o  = perf_id_q;
    assign ctrl.perf_ex_o  = perf_ex_q;
    assign ctrl.perf_mem_o = perf_mem_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: encode table, directed corner sequences and
// randomized traffic against a run-length reference model.
module tb_pipe_ctrl;

    localparam int T = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_ctrl_if ctrl_if ();

    pipe_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: length of the current unbroken run of request edges
    int          run_len;
    int          m_state;
    int          m_cause;
    bit          m_to;
    int unsigned m_perf_id, m_perf_ex, m_perf_mem;

    typedef struct {
        logic       id;
        logic       ex;
        logic       mem;
        logic [5:0] stall;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] exp_stall(input logic id, input logic ex, input logic mem);
        if (mem) return 6'b011111;
        if (ex) return 6'b001111;
        if (id) return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic int exp_cause(input logic id, input logic ex, input logic mem);
        if (mem) return 3;
        if (ex) return 2;
        if (id) return 1;
        return 0;
    endfunction

    task automatic drive(input logic id, input logic ex, input logic mem, input logic clr);
        ctrl_if.stallreq_from_id  = id;
        ctrl_if.stallreq_from_ex  = ex;
        ctrl_if.stallreq_from_mem = mem;
        ctrl_if.timeout_clr_i     = clr;
    endtask

    task automatic model_reset();
        run_len    = 0;
        m_state    = 0;
        m_cause    = 0;
        m_to       = 1'b0;
        m_perf_id  = 0;
        m_perf_ex  = 0;
        m_perf_mem = 0;
    endtask

    // One clock: update the model with the inputs present at the edge
    task automatic tick();
        logic id, ex, mem, clr, any, set;
        id  = ctrl_if.stallreq_from_id;
        ex  = ctrl_if.stallreq_from_ex;
        mem = ctrl_if.stallreq_from_mem;
        clr = ctrl_if.timeout_clr_i;
        @(posedge clk);
        if (rst) begin
            any = id | ex | mem;
            set = 1'b0;
            if (any) begin
                run_len++;
                if (run_len == T) set = 1'b1;
            end else begin
                run_len = 0;
            end
            m_to    = set ? 1'b1 : (clr ? 1'b0 : m_to);
            m_state = any ? ((run_len >= T) ? 2 : 1) : 0;
            m_cause = exp_cause(id, ex, mem);
            case (m_cause)
                1: m_perf_id++;
                2: m_perf_ex++;
                3: m_perf_mem++;
                default: ;
            endcase
        end
        #1;
    endtask

    task automatic check_comb(input string tag);
        check({tag, ".stall"}, 32'(ctrl_if.stall),
              32'(exp_stall(ctrl_if.stallreq_from_id, ctrl_if.stallreq_from_ex,
                            ctrl_if.stallreq_from_mem)));
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".cause"}, 32'(ctrl_if.stall_cause_o), 32'(m_cause));
        check({tag, ".state"}, 32'(ctrl_if.state_o), 32'(m_state));
        check({tag, ".timeout"}, 32'(ctrl_if.timeout_o), 32'(m_to));
`ifdef PIPE_CTRL_PERF_EN
        check({tag, ".perf_id"}, ctrl_if.perf_id_o, m_perf_id);
        check({tag, ".perf_ex"}, ctrl_if.perf_ex_o, m_perf_ex);
        check({tag, ".perf_mem"}, ctrl_if.perf_mem_o, m_perf_mem);
`endif
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 6'b000000, 2'd0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 6'b000111, 2'd1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 6'b001111, 2'd2};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 6'b001111, 2'd2};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 6'b011111, 2'd3};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 6'b011111, 2'd3};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 6'b011111, 2'd3};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 6'b011111, 2'd3};

        model_reset();

        // Reset held with all requests high: stall follows, registers stay cleared
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        check("rst.stall", 32'(ctrl_if.stall), 32'h1F);
        check("rst.cause", 32'(ctrl_if.stall_cause_o), 32'd0);
        check("rst.state", 32'(ctrl_if.state_o), 32'd0);
        check("rst.timeout", 32'(ctrl_if.timeout_o), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_regs("post_rst");

        // Encode table: one request cycle then one idle cycle per vector
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].id, vecs[i].ex, vecs[i].mem, 1'b0);
            #1;
            check($sformatf("vec%0d.stall", i), 32'(ctrl_if.stall), 32'(vecs[i].stall));
            tick();
            check($sformatf("vec%0d.cause", i), 32'(ctrl_if.stall_cause_o), 32'(vecs[i].cause));
            check_regs($sformatf("vec%0d", i));
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            check_regs($sformatf("vec%0d_idle", i));
        end

        // Priority: id+ex for one cycle, round trip back to RUN
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        check("prio.stall", 32'(ctrl_if.stall), 32'h0F);
        tick();
        check("prio.cause", 32'(ctrl_if.stall_cause_o), 32'd2);
        check("prio.state", 32'(ctrl_if.state_o), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("prio.state_run", 32'(ctrl_if.state_o), 32'd0);

        // Watchdog: HUNG and timeout after the T-th edge of ex
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("wd%0d.state", i), 32'(ctrl_if.state_o), (i < T) ? 32'd1 : 32'd2);
            check($sformatf("wd%0d.timeout", i), 32'(ctrl_if.timeout_o), (i < T) ? 32'd0 : 32'd1);
            check($sformatf("wd%0d.stall", i), 32'(ctrl_if.stall), 32'h0F);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check("wd.state_run", 32'(ctrl_if.state_o), 32'd0);
        check("wd.timeout_sticky", 32'(ctrl_if.timeout_o), 32'd1);

        // Clear alone, then clear colliding with a fresh timeout
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("clr.alone", 32'(ctrl_if.timeout_o), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < T; i++) tick();
        check("clr.pre", 32'(ctrl_if.timeout_o), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check("clr.set_wins", 32'(ctrl_if.timeout_o), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("clr.after", 32'(ctrl_if.timeout_o), 32'd0);
        check_regs("clr");

        // Mid-stall reset: count discarded, timeout T edges after release
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        check("mrst.pre_state", 32'(ctrl_if.state_o), 32'd1);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("mrst.state", 32'(ctrl_if.state_o), 32'd0);
        check("mrst.cause", 32'(ctrl_if.stall_cause_o), 32'd0);
        check("mrst.stall", 32'(ctrl_if.stall), 32'h1F);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= T; i++) begin
            tick();
            check($sformatf("mrst%0d.state", i), 32'(ctrl_if.state_o), (i < T) ? 32'd1 : 32'd2);
            check($sformatf("mrst%0d.timeout", i), 32'(ctrl_if.timeout_o), (i < T) ? 32'd0 : 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_regs("mrst.end");

`ifdef PIPE_CTRL_PERF_EN
        // Perf: 5 id, 3 ex, 2 idle from a fresh reset
        rst = 1'b0;
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) tick();
        check("perf.id", ctrl_if.perf_id_o, 32'd5);
        check("perf.ex", ctrl_if.perf_ex_o, 32'd3);
        check("perf.mem", ctrl_if.perf_mem_o, 32'd0);
`endif

        // Randomized traffic with bursty request patterns
        begin
            logic [2:0] pat;
            pat = 3'd0;
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 9) < 3) pat = 3'($urandom_range(0, 7));
                drive(pat[0], pat[1], pat[2], ($urandom_range(0, 7) == 0));
                #1;
                check_comb($sformatf("rnd%0d", c));
                tick();
                check_regs($sformatf("rnd%0d", c));
                if ($urandom_range(0, 99) == 0) begin
                    rst = 1'b0;
                    model_reset();
                    #1;
                    check_regs($sformatf("rnd%0d_rst", c));
                    @(negedge clk);
                    rst = 1'b1;
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
